// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl_if
//  Description : Bundle of the byte-input, SDRAM write-FIFO, SDRAM command
//                and status signals of uart_cmd_ctrl.
//                master : the command controller (uart_cmd_ctrl)
//                slave  : its environment (uart_rx, SDRAM controller/FIFO)
//  Signals     : rx_done, rx_data          byte strobe / byte from uart_rx
//                wfifo_wr, wfifo_data      write strobe / byte to write FIFO
//                cmd_req, cmd_rw, cmd_ack  SDRAM command req/ack handshake
//                frame_err, busy           status
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_cmd_ctrl_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       wfifo_wr;
    logic [7:0] wfifo_data;
    logic       cmd_req;
    logic       cmd_rw;
    logic       cmd_ack;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx_done, rx_data, cmd_ack,
        output wfifo_wr, wfifo_data, cmd_req, cmd_rw, frame_err, busy
    );

    modport slave (
        output rx_done, rx_data, cmd_ack,
        input  wfifo_wr, wfifo_data, cmd_req, cmd_rw, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl
//  Description : UART command frame parser and SDRAM command sequencer.
//                Frame: 0x55, cmd (0xAA write / 0xA5 read), BURST_LEN data
//                bytes for a write, optional check byte. Write payload is
//                buffered, streamed to the SDRAM write FIFO, then one
//                req/ack command is issued. Stalled or malformed frames are
//                dropped with a one-cycle frame_err pulse.
//  Ports       : sysclk  system clock (rising edge)
//                nrst    synchronous active-low reset
//                bus     uart_cmd_ctrl_if.master (rx byte in, write FIFO out,
//                        command handshake, frame_err, busy)
//  Parameters  : BURST_LEN   data bytes per write frame (1..16)
//                TIMEOUT_CYC idle cycles allowed between bytes (< 2^20)
//  Options     : UART_CMD_CHKSUM_EN  adds a trailing check byte equal to the
//                XOR of the cmd byte and all data bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 104160
) (
    input  wire logic            sysclk,
    input  wire logic            nrst,
    uart_cmd_ctrl_if.master      bus
);

    localparam logic [7:0]  c_HDR     = 8'h55;
    localparam logic [7:0]  c_CMD_WR  = 8'hAA;
    localparam logic [7:0]  c_CMD_RD  = 8'hA5;
    localparam logic [3:0]  c_LAST    = 4'(BURST_LEN - 1);
    localparam logic [4:0]  c_BL      = 5'(BURST_LEN);
    localparam logic [19:0] c_TO_LAST = 20'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_REQ   = 3'd4
`ifdef UART_CMD_CHKSUM_EN
        ,
        S_CHK   = 3'd5
`endif
    } state_t;

    state_t      r_state;
    logic        r_byte_vld;
    logic        r_rw;
    logic [3:0]  r_idx;
    logic [4:0]  r_didx;
    logic [19:0] r_to_cnt;
    // Sized for the largest legal burst so a 4-bit index never runs off the end.
    logic [7:0]  r_buf [16];
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_in_frame;
    logic        w_timeout;
    logic [7:0]  w_head;

    // rx_data is only guaranteed from the cycle after rx_done, so every FSM
    // step keys off the delayed strobe.
    always_ff @(posedge sysclk) begin
        if (!nrst) r_byte_vld <= 1'b0;
        else       r_byte_vld <= bus.rx_done;
    end

`ifdef UART_CMD_CHKSUM_EN
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_DATA);
`endif

    // A byte arriving on the expiry cycle still counts, so it wins.
    assign w_timeout = w_in_frame && !r_byte_vld && (r_to_cnt == c_TO_LAST);

    // First drained byte: when the final data byte and the DRAIN entry share
    // a cycle (BURST_LEN == 1, no check byte) buf[0] is not written yet.
    assign w_head = ((r_state == S_DATA) && (r_idx == 4'd0)) ? bus.rx_data : r_buf[0];

    // Payload buffer needs no reset; stale contents are never drained.
    always_ff @(posedge sysclk) begin
        if ((r_state == S_DATA) && r_byte_vld) begin
            r_buf[r_idx] <= bus.rx_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_rw           <= 1'b0;
            r_idx          <= 4'd0;
            r_didx         <= 5'd0;
            r_to_cnt       <= 20'd0;
`ifdef UART_CMD_CHKSUM_EN
            r_xor          <= 8'd0;
`endif
            bus.wfifo_wr   <= 1'b0;
            bus.wfifo_data <= 8'd0;
            bus.cmd_req    <= 1'b0;
            bus.cmd_rw     <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;

            if (r_byte_vld || !w_in_frame) r_to_cnt <= 20'd0;
            else                           r_to_cnt <= r_to_cnt + 20'd1;

            if (w_timeout) begin
                r_state       <= S_IDLE;
                r_idx         <= 4'd0;
                r_to_cnt      <= 20'd0;
                bus.frame_err <= 1'b1;
                bus.busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_byte_vld && (bus.rx_data == c_HDR)) begin
                            r_state  <= S_CMD;
                            bus.busy <= 1'b1;
                        end
                    end

                    S_CMD: begin
                        if (r_byte_vld) begin
`ifdef UART_CMD_CHKSUM_EN
                            r_xor <= bus.rx_data;
`endif
                            if (bus.rx_data == c_CMD_WR) begin
                                r_rw    <= 1'b0;
                                r_idx   <= 4'd0;
                                r_state <= S_DATA;
                            end else if (bus.rx_data == c_CMD_RD) begin
                                r_rw <= 1'b1;
`ifdef UART_CMD_CHKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state     <= S_REQ;
                                bus.cmd_req <= 1'b1;
                                bus.cmd_rw  <= 1'b1;
`endif
                            end else begin
                                r_state       <= S_IDLE;
                                bus.frame_err <= 1'b1;
                                bus.busy      <= 1'b0;
                            end
                        end
                    end

                    S_DATA: begin
                        if (r_byte_vld) begin
                            r_idx <= r_idx + 4'd1;
`ifdef UART_CMD_CHKSUM_EN
                            r_xor <= r_xor ^ bus.rx_data;
`endif
                            if (r_idx == c_LAST) begin
`ifdef UART_CMD_CHKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state        <= S_DRAIN;
                                r_didx         <= 5'd1;
                                bus.wfifo_wr   <= 1'b1;
                                bus.wfifo_data <= w_head;
`endif
                            end
                        end
                    end

`ifdef UART_CMD_CHKSUM_EN
                    S_CHK: begin
                        if (r_byte_vld) begin
                            if (bus.rx_data != r_xor) begin
                                r_state       <= S_IDLE;
                                bus.frame_err <= 1'b1;
                                bus.busy      <= 1'b0;
                            end else if (r_rw) begin
                                r_state     <= S_REQ;
                                bus.cmd_req <= 1'b1;
                                bus.cmd_rw  <= 1'b1;
                            end else begin
                                r_state        <= S_DRAIN;
                                r_didx         <= 5'd1;
                                bus.wfifo_wr   <= 1'b1;
                                bus.wfifo_data <= w_head;
                            end
                        end
                    end
`endif

                    // Byte 0 was launched on entry; r_didx is the next byte.
                    S_DRAIN: begin
                        if (r_didx == c_BL) begin
                            r_state      <= S_REQ;
                            bus.wfifo_wr <= 1'b0;
                            bus.cmd_req  <= 1'b1;
                            bus.cmd_rw   <= r_rw;
                        end else begin
                            bus.wfifo_wr   <= 1'b1;
                            bus.wfifo_data <= r_buf[r_didx[3:0]];
                            r_didx         <= r_didx + 5'd1;
                        end
                    end

                    S_REQ: begin
                        if (bus.cmd_ack) begin
                            r_state     <= S_IDLE;
                            bus.cmd_req <= 1'b0;
                            bus.cmd_rw  <= 1'b0;
                            bus.busy    <= 1'b0;
                        end
                    end

                    default: begin
                        r_state  <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_ctrl
//  Description : Directed self-checking bench for uart_cmd_ctrl
//                (BURST_LEN = 4, shortened TIMEOUT_CYC). Honours
//                UART_CMD_CHKSUM_EN by appending check bytes to frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int BL = 4;
    localparam int TO = 64;

    logic sysclk = 1'b0;
    logic nrst   = 1'b0;
    int   tot    = 0;
    int   bad    = 0;

    always #5 sysclk = ~sysclk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .BURST_LEN   (BL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sysclk (sysclk),
        .nrst   (nrst),
        .bus    (bus.master)
    );

    // Passive monitor: collects strobed bytes and counts req / error cycles.
    logic [7:0] wq [$];
    int         n_req = 0;
    int         n_err = 0;

    always @(negedge sysclk) begin
        if (bus.wfifo_wr)  wq.push_back(bus.wfifo_data);
        if (bus.cmd_req)   n_req++;
        if (bus.frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rx_done pulses one cycle; rx_data stays put until the next byte.
    // Returns #1 into the cycle in which the DUT's byte_vld is high.
    task automatic send_byte(input logic [7:0] b);
        @(posedge sysclk); #1;
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(posedge sysclk); #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_read();
        send_byte(8'h55);
        send_byte(8'hA5);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hA5);
`endif
    endtask

    task automatic send_write(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(d0);
        send_byte(d1);
        send_byte(d2);
        send_byte(d3);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hAA ^ d0 ^ d1 ^ d2 ^ d3);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wexp [4];
        int         w0;
        int         r0;
        int         e0;
        int         n;

        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.cmd_ack = 1'b0;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_wfifo_wr",   32'(bus.wfifo_wr),   32'd0);
        check("rst_wfifo_data", 32'(bus.wfifo_data), 32'd0);
        check("rst_cmd_req",    32'(bus.cmd_req),    32'd0);
        check("rst_cmd_rw",     32'(bus.cmd_rw),     32'd0);
        check("rst_frame_err",  32'(bus.frame_err),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        nrst = 1'b1;
        idle(2);

        // ---------------- garbage in IDLE is silent ----------------
        e0 = n_err;
        send_byte(8'h07);
        idle(3);
        check("idle_garbage_err",  32'(n_err - e0), 32'd0);
        check("idle_garbage_busy", 32'(bus.busy),   32'd0);

        // ---------------- write frame 55 AA 11 22 33 44 ----------------
        wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;
        send_byte(8'h55);
        @(negedge sysclk);
        check("busy_before_hdr_step", 32'(bus.busy), 32'd0);
        @(negedge sysclk);
        check("busy_after_hdr", 32'(bus.busy), 32'd1);
        send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hAA ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
        @(negedge sysclk);
        check("wr_no_early_strobe", 32'(bus.wfifo_wr), 32'd0);
        for (int i = 0; i < BL; i++) begin
            @(negedge sysclk);
            check("wr_strobe",  32'(bus.wfifo_wr),   32'd1);
            check("wr_data",    32'(bus.wfifo_data), 32'(wexp[i]));
            check("wr_no_req",  32'(bus.cmd_req),    32'd0);
        end
        @(negedge sysclk);
        check("wr_strobe_end", 32'(bus.wfifo_wr), 32'd0);
        check("wr_req_rise",   32'(bus.cmd_req),  32'd1);
        check("wr_rw",         32'(bus.cmd_rw),   32'd0);
        @(negedge sysclk);
        check("wr_req_hold1", 32'(bus.cmd_req), 32'd1);
        @(negedge sysclk);
        check("wr_req_hold2", 32'(bus.cmd_req), 32'd1);
        bus.cmd_ack = 1'b1;
        @(negedge sysclk);
        check("wr_req_fall", 32'(bus.cmd_req), 32'd0);
        check("wr_busy_fall", 32'(bus.busy),   32'd0);
        bus.cmd_ack = 1'b0;
        idle(2);

        // ---------------- read frame, ack tied high ----------------
        w0 = wq.size();
        bus.cmd_ack = 1'b1;
        send_read();
        @(negedge sysclk);
        check("rd_req_not_yet", 32'(bus.cmd_req), 32'd0);
        @(negedge sysclk);
        check("rd_req_rise", 32'(bus.cmd_req), 32'd1);
        check("rd_rw",       32'(bus.cmd_rw),  32'd1);
        @(negedge sysclk);
        check("rd_req_one_cycle", 32'(bus.cmd_req), 32'd0);
        check("rd_busy_fall",     32'(bus.busy),    32'd0);
        check("rd_no_wfifo",      32'(wq.size() - w0), 32'd0);

        // ---------------- bad cmd, then garbage, then read ----------------
        w0 = wq.size(); r0 = n_req; e0 = n_err;
        send_byte(8'h55);
        send_byte(8'h3C);
        @(negedge sysclk);
        check("badcmd_err_not_yet", 32'(bus.frame_err), 32'd0);
        @(negedge sysclk);
        check("badcmd_err_pulse", 32'(bus.frame_err), 32'd1);
        check("badcmd_busy",      32'(bus.busy),      32'd0);
        @(negedge sysclk);
        check("badcmd_err_width", 32'(bus.frame_err), 32'd0);
        send_byte(8'h07);
        idle(4);
        check("badcmd_err_count", 32'(n_err - e0),     32'd1);
        check("badcmd_no_wfifo",  32'(wq.size() - w0), 32'd0);
        check("badcmd_no_req",    32'(n_req - r0),     32'd0);
        r0 = n_req;
        send_read();
        idle(4);
        check("after_bad_read_req", 32'(n_req - r0), 32'd1);

        // ---------------- timeout mid-frame ----------------
        e0 = n_err; w0 = wq.size();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h11);
        n = TO * 3;
        for (int k = 1; k <= TO * 3; k++) begin
            @(negedge sysclk);
            if (bus.frame_err) begin
                n = k;
                break;
            end
        end
        check("to_latency_window", 32'((n >= TO) && (n <= TO + 2)), 32'd1);
        @(negedge sysclk);
        check("to_busy",      32'(bus.busy),     32'd0);
        check("to_err_count", 32'(n_err - e0),   32'd1);
        send_write(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        idle(BL + 4);
        check("to_next_count", 32'(wq.size() - w0), 32'(BL));
        if (wq.size() - w0 == BL) begin
            check("to_next_b0", 32'(wq[w0]),     32'h0A1);
            check("to_next_b3", 32'(wq[w0 + 3]), 32'h0D4);
        end

`ifdef UART_CMD_CHKSUM_EN
        // ---------------- check byte paths ----------------
        r0 = n_req; w0 = wq.size(); e0 = n_err;
        send_byte(8'h55); send_byte(8'hA5); send_byte(8'hA5);
        idle(4);
        check("chk_rd_req", 32'(n_req - r0), 32'd1);
        r0 = n_req;
        send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hAE);
        idle(BL + 4);
        check("chk_wr_strobes", 32'(wq.size() - w0), 32'(BL));
        check("chk_wr_req",     32'(n_req - r0),     32'd1);
        r0 = n_req; w0 = wq.size();
        send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hAF);
        idle(BL + 4);
        check("chk_bad_err",    32'(n_err - e0),     32'd1);
        check("chk_bad_no_wr",  32'(wq.size() - w0), 32'd0);
        check("chk_bad_no_req", 32'(n_req - r0),     32'd0);
`endif
        bus.cmd_ack = 1'b0;

        // ---------------- reset during DRAIN ----------------
        send_write(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        @(negedge sysclk);
        @(negedge sysclk);
        check("rstdrain_s1", 32'(bus.wfifo_data), 32'h05A);
        @(negedge sysclk);
        check("rstdrain_s2_wr",   32'(bus.wfifo_wr),   32'd1);
        check("rstdrain_s2_data", 32'(bus.wfifo_data), 32'h06B);
        nrst = 1'b0;
        @(negedge sysclk);
        check("rstdrain_wr",   32'(bus.wfifo_wr),   32'd0);
        check("rstdrain_data", 32'(bus.wfifo_data), 32'd0);
        check("rstdrain_req",  32'(bus.cmd_req),    32'd0);
        check("rstdrain_busy", 32'(bus.busy),       32'd0);
        check("rstdrain_err",  32'(bus.frame_err),  32'd0);
        idle(2);
        nrst = 1'b1;
        idle(2);
        w0 = wq.size(); r0 = n_req;
        bus.cmd_ack = 1'b1;
        send_write(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        idle(BL + 4);
        check("post_rst_count", 32'(wq.size() - w0), 32'(BL));
        check("post_rst_req",   32'(n_req - r0),     32'd1);
        if (wq.size() - w0 == BL) begin
            check("post_rst_b2", 32'(wq[w0 + 2]), 32'h0C2);
        end
        bus.cmd_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
